msi_irq_arbiter: RTL and testbench
==================================

MSI_IRQ_ARBITER -- requirements
Module: msi_irq_arbiter

Interface
REQ-001 Parameter N, default 4: number of interrupt channels, legal range 1..32.
REQ-002 Parameter GAP, default 2: holdoff cycles after each grant before the next request, legal range 0..15.
REQ-003 Parameter LEVEL_MASK, N bits, default all-zero: bit i=1 makes channel i level-sensitive; bit i=0 makes it rising-edge-sensitive.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, named as follows.
  - clk  in  1: sole clock.
  - rst  in  1: synchronous active-high reset.
REQ-005 The interrupt-side ports SHALL be:
  - irq_i  in  N: interrupt sources, synchronous to clk.
  - irq_mask_i  in  N: 1 = channel masked; no pending set, existing pending retained.
  - msi_enabled  in  1: from PCIe core; 0 inhibits requests.
REQ-006 The PCIe-side and status ports SHALL be:
  - msi_request  out  1: MSI request to PCIe core.
  - msi_grant  in  1: one-cycle grant from PCIe core.
  - msi_vector_o  out  VW: channel index being requested, where VW = max(1, clog2(N)).
  - pending_o  out  N: per-channel pending flags.
  - overflow_o  out  N: sticky; an edge arrived while that channel was already pending.

Function
REQ-007 Edge channels SHALL register irq_i into irq_p each cycle, with edge = irq_i & ~irq_p.
REQ-008 An unmasked edge at cycle t SHALL set pending[i] visible at t+1.
REQ-009 A level channel SHALL set pending[i] whenever irq_i[i]=1, it is unmasked, and it is not the channel currently in REQ.
REQ-010 An edge on a channel already pending SHALL set overflow_o[i]; the edges coalesce into one MSI.
REQ-011 The FSM SHALL have the states IDLE, REQ and HOLD, defined as follows.
  - IDLE: if msi_enabled and |pending, latch the round-robin winner into msi_vector_o, go to REQ.
  - REQ: msi_request=1 and msi_vector_o stable. On msi_grant, go to HOLD (or to IDLE if GAP=0).
  - HOLD: count GAP cycles, then go to IDLE.
REQ-012 Request latency SHALL be as follows: edge at cycle t, pending at t+1, msi_request at t+2, given IDLE with msi_enabled=1.
REQ-013 On the grant cycle, pending[vector] SHALL clear, unless a new edge on that channel occurs in the same cycle, in which case it stays set and overflow is not set.
REQ-014 Round-robin SHALL search starting at last-granted+1, wrapping at N-1 to 0; after reset the search starts at channel 0.
REQ-015 If msi_enabled falls while in REQ, msi_request SHALL drop the next cycle, the FSM goes to IDLE, pending is retained and the pointer is unchanged.
REQ-016 msi_grant received in IDLE or HOLD SHALL be ignored.
REQ-017 Masking a channel while it is in REQ SHALL NOT withdraw the request.
REQ-018 msi_request SHALL never assert for more than one channel per grant, and SHALL be deasserted in the cycle after the grant.

Reset
REQ-019 On rst, the block SHALL reset as follows.
  - State = IDLE.
  - msi_request=0, msi_vector_o=0, pending_o=0, overflow_o=0.
  - irq_p=0, holdoff counter=0, round-robin pointer such that channel 0 has first priority.
REQ-020 rst asserted mid-REQ SHALL drop msi_request in the next cycle; a grant in that cycle is ignored.
REQ-021 An edge channel that is already high when rst deasserts SHALL raise no interrupt until its next rising edge.

Structure
REQ-022 Package msi_irq_pkg SHALL hold the following.
  - The state enum (IDLE/REQ/HOLD).
  - A vector-width function vw(N).
  - Constants MAX_N=32 and MAX_GAP=15.
REQ-023 The design SHALL use one sub-module, rr_arbiter: parameter N; inputs req[N] and last index; outputs one-hot grant and index; purely combinational; instantiated once.
REQ-024 The block SHALL contain no other clock domain; CDC of irq_i is the instantiator's responsibility.

Verification
REQ-025 Single edge: N=4, GAP=2, msi_enabled=1, irq_i[2] rises at cycle 10.
  - msi_request=1 and vector=2 at cycle 12.
  - Grant at cycle 15: request drops at cycle 16 and pending_o=0.
REQ-026 Round-robin: channels 0, 1 and 3 rise in the same cycle, grants are immediate, GAP=2.
  - Vectors issue in the order 0, 1, 3.
  - Consecutive requests are separated by 2 idle cycles.
REQ-027 Coalesce and overflow: channel 1 pulses 3 times while msi_enabled=0, then msi_enabled=1.
  - Exactly one MSI with vector=1.
  - overflow_o[1]=1 until rst.
REQ-028 Enable drop: msi_enabled falls while in REQ for vector 3.
  - Request drops the next cycle and pending[3] is held.
  - Re-enable: vector 3 is re-requested 1 cycle after returning to IDLE.
REQ-029 Level channel: LEVEL_MASK=4'b0100 and irq_i[2] held high.
  - Repeated MSIs with vector=2, one per grant+GAP.
  - Lowering irq_i[2] before a grant causes no further MSIs after the pending one.
REQ-030 Reset mid-request: rst in REQ with simultaneous msi_grant.
  - All outputs are 0 the next cycle.
  - A high irq_i edge channel produces no MSI until it toggles.

Source files
------------

// File: rtl/msi_irq_pkg.sv
// Shared types and helpers for the MSI interrupt arbiter: FSM encoding,
// vector-width helper and parameter limits.
package msi_irq_pkg;

  localparam int MAX_N   = 32;
  localparam int MAX_GAP = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int vw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/msi_irq_arbiter_rr.sv
// Combinational round-robin picker: the search starts one past the last
// granted index and wraps from N-1 back to 0.
module rr_arbiter
  import msi_irq_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     req,
  input  logic [vw(N)-1:0] last,
  output logic [N-1:0]     grant,
  output logic [vw(N)-1:0] idx
);

  localparam int VW = vw(N);

  int c;

  // Walk from the lowest priority to the highest so the last hit wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    c     = 0;
    for (int k = N; k >= 1; k--) begin
      c = (int'(last) + k) % N;
      if (req[c]) begin
        grant    = '0;
        grant[c] = 1'b1;
        idx      = VW'(c);
      end
    end
  end

endmodule

// File: rtl/msi_irq_arbiter.sv
// Collects edge/level interrupt sources into pending flags and serialises
// them as MSI requests to the PCIe core with a post-grant holdoff.
module msi_irq_arbiter
  import msi_irq_pkg::*;
#(
  parameter int           N          = 4,
  parameter int           GAP        = 2,
  parameter logic [N-1:0] LEVEL_MASK = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     irq_i,
  input  logic [N-1:0]     irq_mask_i,
  input  logic             msi_enabled,
  output logic             msi_request,
  input  logic             msi_grant,
  output logic [vw(N)-1:0] msi_vector_o,
  output logic [N-1:0]     pending_o,
  output logic [N-1:0]     overflow_o,
  output logic [1:0]       state_dbg
);

  localparam int VW = vw(N);

  state_e        state;
  logic [N-1:0]  irq_p;
  logic [N-1:0]  edge_det;
  logic [N-1:0]  set_pend;
  logic [N-1:0]  clr_pend;
  logic [N-1:0]  rr_grant;
  logic [VW-1:0] rr_idx;
  logic [VW-1:0] last_q;
  logic [3:0]    hold_cnt;
  logic          rst_q;
  logic          grant_ok;

  // Handshake: msi_request stays high with msi_vector_o frozen until a
  // one-cycle msi_grant is seen in REQ; the request drops the next cycle.
  assign msi_request = (state == REQ);
  assign state_dbg   = state;
  assign grant_ok    = (state == REQ) && msi_grant;

  // The first cycle out of reset is blanked so a line already high is not
  // taken for a fresh rising edge.
  assign edge_det = irq_i & ~irq_p & ~LEVEL_MASK & {N{~rst_q}};

  always_comb begin
    set_pend = '0;
    clr_pend = '0;
    for (int i = 0; i < N; i++) begin
      if (LEVEL_MASK[i])
        set_pend[i] = irq_i[i] && !((state == REQ) && (int'(msi_vector_o) == i));
      else
        set_pend[i] = edge_det[i];
      clr_pend[i] = grant_ok && (int'(msi_vector_o) == i);
    end
    set_pend = set_pend & ~irq_mask_i;
  end

  rr_arbiter #(.N(N)) u_rr (
    .req   (pending_o),
    .last  (last_q),
    .grant (rr_grant),
    .idx   (rr_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      msi_vector_o <= '0;
      pending_o    <= '0;
      overflow_o   <= '0;
      irq_p        <= '0;
      hold_cnt     <= '0;
      last_q       <= VW'(N - 1);
      rst_q        <= 1'b1;
    end else begin
      rst_q      <= 1'b0;
      irq_p      <= irq_i;
      pending_o  <= (pending_o & ~clr_pend) | set_pend;
      // A new edge landing on the grant cycle re-arms pending instead of overflowing.
      overflow_o <= overflow_o | (edge_det & ~irq_mask_i & pending_o & ~clr_pend);
      case (state)
        IDLE: begin
          if (msi_enabled && |rr_grant) begin
            msi_vector_o <= rr_idx;
            state        <= REQ;
          end
        end
        REQ: begin
          if (msi_grant) begin
            last_q   <= msi_vector_o;
            hold_cnt <= '0;
            state    <= (GAP == 0) ? IDLE : HOLD;
          end else if (!msi_enabled) begin
            state <= IDLE;
          end
        end
        HOLD: begin
          if (int'(hold_cnt) + 1 >= GAP) state <= IDLE;
          else hold_cnt <= hold_cnt + 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msi_irq_arbiter.sv
// Self-checking bench for msi_irq_arbiter: an edge-only instance and an
// instance with channel 2 level-sensitive share stimulus.
module tb_msi_irq_arbiter;
  import msi_irq_pkg::*;

  localparam int N   = 4;
  localparam int GAP = 2;
  localparam int VW  = vw(N);

  logic          clk     = 1'b0;
  logic          rst     = 1'b1;
  logic [N-1:0]  irq     = '0;
  logic [N-1:0]  mask    = '0;
  logic          en      = 1'b1;
  logic          grant_e = 1'b0;
  logic          grant_l = 1'b0;
  logic          req_e, req_l;
  logic [VW-1:0] vec_e, vec_l;
  logic [N-1:0]  pend_e, pend_l, ovf_e, ovf_l;
  logic [1:0]    st_e, st_l;

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;
  logic [VW-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  msi_irq_arbiter #(.N(N), .GAP(GAP), .LEVEL_MASK(4'b0000)) dut_e (
    .clk(clk), .rst(rst), .irq_i(irq), .irq_mask_i(mask), .msi_enabled(en),
    .msi_request(req_e), .msi_grant(grant_e), .msi_vector_o(vec_e),
    .pending_o(pend_e), .overflow_o(ovf_e), .state_dbg(st_e)
  );

  msi_irq_arbiter #(.N(N), .GAP(GAP), .LEVEL_MASK(4'b0100)) dut_l (
    .clk(clk), .rst(rst), .irq_i(irq), .irq_mask_i(mask), .msi_enabled(en),
    .msi_request(req_l), .msi_grant(grant_l), .msi_vector_o(vec_l),
    .pending_o(pend_l), .overflow_o(ovf_l), .state_dbg(st_l)
  );

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; irq = '0; mask = '0; en = 1'b1; grant_e = 1'b0; grant_l = 1'b0;
    step(2);
    rst = 1'b0;
    step();
  endtask

  task automatic wait_req(input bit lvl, input int budget, output bit ok,
                          output logic [VW-1:0] v, output int at);
    ok = 1'b0; v = '0; at = -1;
    for (int i = 0; i < budget; i++) begin
      if ((lvl ? req_l : req_e) === 1'b1) begin
        ok = 1'b1; v = lvl ? vec_l : vec_e; at = cyc;
        return;
      end
      step();
    end
  endtask

  task automatic give_grant(input bit lvl);
    if (lvl) grant_l = 1'b1; else grant_e = 1'b1;
    step();
    grant_e = 1'b0; grant_l = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; irq = '0; mask = '0; en = 1'b1;
    step(3);
    n_checks++; if (req_e !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", req_e); end
    n_checks++; if (vec_e !== '0) begin n_fail++; $display("FAIL reset_vec: got %0d want 0", vec_e); end
    n_checks++; if (pend_e !== '0 || ovf_e !== '0) begin n_fail++; $display("FAIL reset_flags: got pend=%b ovf=%b want 0000/0000", pend_e, ovf_e); end
    n_checks++; if (st_e !== IDLE || st_l !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d/%0d want 0/0", st_e, st_l); end
    n_checks++; if (req_l !== 1'b0 || pend_l !== '0) begin n_fail++; $display("FAIL reset_lvl: got req=%b pend=%b want 0/0000", req_l, pend_l); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_edge();
    logic [VW-1:0] exp;
    do_reset();
    step(2);
    irq[2] = 1'b1; exp_q.push_back(VW'(2));
    step();
    n_checks++; if (pend_e !== 4'b0100 || req_e !== 1'b0) begin n_fail++; $display("FAIL edge_pending_t1: got pend=%b req=%b want 0100/0", pend_e, req_e); end
    step();
    exp = exp_q.pop_front();
    n_checks++; if (req_e !== 1'b1 || vec_e !== exp) begin n_fail++; $display("FAIL edge_request_t2: got req=%b vec=%0d want 1/%0d", req_e, vec_e, exp); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (req_e !== 1'b1 || vec_e !== exp) begin n_fail++; $display("FAIL edge_request_hold: got req=%b vec=%0d want 1/%0d", req_e, vec_e, exp); end
    end
    give_grant(1'b0);
    n_checks++; if (req_e !== 1'b0 || pend_e !== '0 || st_e !== HOLD) begin n_fail++; $display("FAIL edge_after_grant: got req=%b pend=%b st=%0d want 0/0000/2", req_e, pend_e, st_e); end
    give_grant(1'b0);
    n_checks++; if (st_e !== HOLD || pend_e !== '0) begin n_fail++; $display("FAIL grant_in_hold: got st=%0d pend=%b want 2/0000", st_e, pend_e); end
    step();
    n_checks++; if (st_e !== IDLE || req_e !== 1'b0) begin n_fail++; $display("FAIL hold_length: got st=%0d req=%b want 0/0", st_e, req_e); end
    irq[2] = 1'b0;
    step();
  endtask

  task automatic test_round_robin();
    bit ok; logic [VW-1:0] v, exp; int at, prev;
    do_reset();
    irq = 4'b1011;
    exp_q.push_back(VW'(0)); exp_q.push_back(VW'(1)); exp_q.push_back(VW'(3));
    step();
    irq = '0;
    prev = 0;
    for (int i = 0; i < 3; i++) begin
      wait_req(1'b0, 20, ok, v, at);
      exp = exp_q.pop_front();
      n_checks++; if (!ok || v !== exp) begin n_fail++; $display("FAIL rr_order_%0d: got ok=%b vec=%0d want 1/%0d", i, ok, v, exp); end
      if (i > 0) begin
        n_checks++; if (at - prev !== GAP + 2) begin n_fail++; $display("FAIL rr_spacing_%0d: got %0d cycles want %0d", i, at - prev, GAP + 2); end
      end
      prev = at;
      give_grant(1'b0);
      n_checks++; if (req_e !== 1'b0) begin n_fail++; $display("FAIL rr_drop_%0d: got req=%b want 0", i, req_e); end
    end
    wait_req(1'b0, 10, ok, v, at);
    n_checks++; if (ok !== 1'b0 || pend_e !== '0) begin n_fail++; $display("FAIL rr_drained: got extra=%b pend=%b want 0/0000", ok, pend_e); end
  endtask

  task automatic test_coalesce();
    bit ok; logic [VW-1:0] v, exp; int at;
    do_reset();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      irq[1] = 1'b1; step();
      irq[1] = 1'b0; step();
    end
    n_checks++; if (pend_e !== 4'b0010 || ovf_e !== 4'b0010 || req_e !== 1'b0) begin n_fail++; $display("FAIL coalesce_flags: got pend=%b ovf=%b req=%b want 0010/0010/0", pend_e, ovf_e, req_e); end
    en = 1'b1; exp_q.push_back(VW'(1));
    wait_req(1'b0, 10, ok, v, at);
    exp = exp_q.pop_front();
    n_checks++; if (!ok || v !== exp) begin n_fail++; $display("FAIL coalesce_vec: got ok=%b vec=%0d want 1/%0d", ok, v, exp); end
    give_grant(1'b0);
    wait_req(1'b0, 12, ok, v, at);
    n_checks++; if (ok !== 1'b0) begin n_fail++; $display("FAIL coalesce_single: got second request vec=%0d want none", v); end
    n_checks++; if (ovf_e !== 4'b0010) begin n_fail++; $display("FAIL overflow_sticky: got %b want 0010", ovf_e); end
    do_reset();
    n_checks++; if (ovf_e !== '0) begin n_fail++; $display("FAIL overflow_reset: got %b want 0000", ovf_e); end
  endtask

  task automatic test_mask();
    bit ok; logic [VW-1:0] v, exp; int at;
    do_reset();
    en = 1'b0; mask = 4'b0001; irq[0] = 1'b1;
    step();
    n_checks++; if (pend_e !== '0) begin n_fail++; $display("FAIL mask_blocks_set: got pend=%b want 0000", pend_e); end
    irq[0] = 1'b0; mask = '0; irq[1] = 1'b1;
    step();
    mask = 4'b0010;
    step(2);
    n_checks++; if (pend_e !== 4'b0010) begin n_fail++; $display("FAIL mask_retains: got pend=%b want 0010", pend_e); end
    en = 1'b1; irq[1] = 1'b0; exp_q.push_back(VW'(1));
    wait_req(1'b0, 10, ok, v, at);
    exp = exp_q.pop_front();
    n_checks++; if (!ok || v !== exp) begin n_fail++; $display("FAIL mask_request: got ok=%b vec=%0d want 1/%0d", ok, v, exp); end
    give_grant(1'b0);
    mask = '0;
  endtask

  task automatic test_enable_drop();
    bit ok; logic [VW-1:0] v, exp; int at;
    do_reset();
    irq[3] = 1'b1; exp_q.push_back(VW'(3));
    wait_req(1'b0, 10, ok, v, at);
    exp = exp_q.pop_front();
    n_checks++; if (!ok || v !== exp) begin n_fail++; $display("FAIL endrop_first: got ok=%b vec=%0d want 1/%0d", ok, v, exp); end
    en = 1'b0;
    step();
    n_checks++; if (req_e !== 1'b0 || pend_e[3] !== 1'b1 || st_e !== IDLE) begin n_fail++; $display("FAIL endrop_drop: got req=%b pend=%b st=%0d want 0/1xxx/0", req_e, pend_e, st_e); end
    en = 1'b1; exp_q.push_back(VW'(3));
    step();
    exp = exp_q.pop_front();
    n_checks++; if (req_e !== 1'b1 || vec_e !== exp) begin n_fail++; $display("FAIL endrop_rerequest: got req=%b vec=%0d want 1/%0d", req_e, vec_e, exp); end
    mask = 4'b1000;
    step();
    n_checks++; if (req_e !== 1'b1 || vec_e !== VW'(3)) begin n_fail++; $display("FAIL mask_in_req: got req=%b vec=%0d want 1/3", req_e, vec_e); end
    give_grant(1'b0);
    n_checks++; if (req_e !== 1'b0 || pend_e !== '0) begin n_fail++; $display("FAIL endrop_grant: got req=%b pend=%b want 0/0000", req_e, pend_e); end
    mask = '0; irq[3] = 1'b0;
  endtask

  task automatic test_level();
    bit ok; logic [VW-1:0] v, exp; int at, prev;
    do_reset();
    irq[2] = 1'b1;
    prev = 0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(VW'(2));
      wait_req(1'b1, 12, ok, v, at);
      exp = exp_q.pop_front();
      n_checks++; if (!ok || v !== exp) begin n_fail++; $display("FAIL level_vec_%0d: got ok=%b vec=%0d want 1/%0d", i, ok, v, exp); end
      if (i > 0) begin
        n_checks++; if (at - prev !== GAP + 2) begin n_fail++; $display("FAIL level_spacing_%0d: got %0d cycles want %0d", i, at - prev, GAP + 2); end
      end
      prev = at;
      give_grant(1'b1);
      n_checks++; if (req_l !== 1'b0 || pend_l !== '0) begin n_fail++; $display("FAIL level_clear_%0d: got req=%b pend=%b want 0/0000", i, req_l, pend_l); end
    end
    step();
    irq[2] = 1'b0; exp_q.push_back(VW'(2));
    wait_req(1'b1, 12, ok, v, at);
    exp = exp_q.pop_front();
    n_checks++; if (!ok || v !== exp) begin n_fail++; $display("FAIL level_last: got ok=%b vec=%0d want 1/%0d", ok, v, exp); end
    give_grant(1'b1);
    wait_req(1'b1, 12, ok, v, at);
    n_checks++; if (ok !== 1'b0 || pend_l !== '0) begin n_fail++; $display("FAIL level_stop: got extra=%b pend=%b want 0/0000", ok, pend_l); end
  endtask

  task automatic test_reset_mid_req();
    bit ok; logic [VW-1:0] v, exp; int at;
    do_reset();
    irq[1] = 1'b1;
    wait_req(1'b0, 10, ok, v, at);
    n_checks++; if (!ok || v !== VW'(1)) begin n_fail++; $display("FAIL rstreq_setup: got ok=%b vec=%0d want 1/1", ok, v); end
    rst = 1'b1; grant_e = 1'b1;
    step();
    rst = 1'b0; grant_e = 1'b0;
    n_checks++; if (req_e !== 1'b0 || vec_e !== '0 || pend_e !== '0 || ovf_e !== '0 || st_e !== IDLE) begin n_fail++; $display("FAIL rstreq_outputs: got req=%b vec=%0d pend=%b ovf=%b st=%0d want all 0", req_e, vec_e, pend_e, ovf_e, st_e); end
    wait_req(1'b0, 10, ok, v, at);
    n_checks++; if (ok !== 1'b0 || pend_e !== '0) begin n_fail++; $display("FAIL rstreq_high_line: got req=%b pend=%b want 0/0000", ok, pend_e); end
    irq[1] = 1'b0; step();
    irq[1] = 1'b1; exp_q.push_back(VW'(1));
    wait_req(1'b0, 10, ok, v, at);
    exp = exp_q.pop_front();
    n_checks++; if (!ok || v !== exp) begin n_fail++; $display("FAIL rstreq_toggle: got ok=%b vec=%0d want 1/%0d", ok, v, exp); end
    give_grant(1'b0);
    irq = '0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_edge();
    test_round_robin();
    test_coalesce();
    test_mask();
    test_enable_drop();
    test_level();
    test_reset_mid_req();
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
